// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants and types for the UART TX scheduler:
// port map, config bit layout, FSM states and line config.
package uart_tx_scheduler_pkg;

   localparam logic [15:0] DATA_PORT_ADDR = 16'h0000;
   localparam logic [15:0] CFG_PORT_ADDR  = 16'h0001;
   localparam logic [15:0] STAT_PORT_ADDR = 16'h0002;

   localparam int CFG_BAUD_LSB = 0;
   localparam int CFG_BAUD_MSB = 3;
   localparam int CFG_EIGHT    = 4;
   localparam int CFG_PEN      = 5;
   localparam int CFG_OHEL     = 6;
   localparam int CFG_INTEN    = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } tx_state_e;

   typedef struct packed {
      logic [3:0] baud;
      logic       eight;
      logic       pen;
      logic       ohel;
   } line_cfg_t;

   localparam line_cfg_t LINE_CFG_RST = '{
      baud:  4'h0,
      eight: 1'b1,
      pen:   1'b0,
      ohel:  1'b0
   };

   function automatic line_cfg_t cfg_decode(input logic [7:0] b);
      line_cfg_t c;
      c.baud  = b[CFG_BAUD_MSB:CFG_BAUD_LSB];
      c.eight = b[CFG_EIGHT];
      c.pen   = b[CFG_PEN];
      c.ohel  = b[CFG_OHEL];
      return c;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// Small synchronous FIFO; a push while full is still taken
// when a pop happens in the same cycle.
module sync_fifo
   import uart_tx_scheduler_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [W-1:0]            data_i,
   output logic [W-1:0]            data_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // pointer and occupancy next-state
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // storage; contents are don't-care while empty
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers processor bytes and paces them into the UART TX
// engine one frame at a time, with shadowed line config.
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter int          LOW_WATER = 2,
   parameter logic [15:0] DATA_PORT = DATA_PORT_ADDR,
   parameter logic [15:0] CFG_PORT  = CFG_PORT_ADDR,
   parameter logic [15:0] STAT_PORT = STAT_PORT_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] port_id,
   input  logic        write_strobe,
   input  logic [15:0] out_port,
   output logic [15:0] in_port,
   input  logic        interrupt_ack,
   output logic        interrupt,
   input  logic        tx_rdy,
   output logic        tx_load,
   output logic [7:0]  tx_data,
   output logic [3:0]  baud_sel,
   output logic        eight,
   output logic        pen,
   output logic        ohel
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] LW_HI = CW'(LOW_WATER + 1);

   logic          data_wr, cfg_wr, stat_wr;
   logic          fifo_full, fifo_empty, pop;
   logic [7:0]    fifo_head;
   logic [CW-1:0] fifo_count;
   tx_state_e     state_q, state_d;
   line_cfg_t     shadow_q, shadow_d;
   line_cfg_t     line_q, line_d;
   logic          int_en_q, int_en_d;
   logic          pend_q, pend_d;
   logic          ovf_q, ovf_d;
   logic          irq_q, irq_d;
   logic [7:0]    txd_q, txd_d;
   logic          apply, irq_set;
   logic [31:0]   cnt_ext;
   logic [3:0]    cnt_disp;
   logic          unused_hi;

   assign data_wr   = write_strobe && (port_id == DATA_PORT);
   assign cfg_wr    = write_strobe && (port_id == CFG_PORT);
   assign stat_wr   = write_strobe && (port_id == STAT_PORT);
   assign unused_hi = ^out_port[15:8];

   sync_fifo #(
      .W     (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (data_wr),
      .pop_i   (pop),
      .data_i  (out_port[7:0]),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // launch sequencer; config application beats a launch
   always_comb begin
      state_d = state_q;
      apply   = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (tx_rdy && pend_q) begin
               apply = 1'b1;
            end else if (tx_rdy && !fifo_empty) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            pop     = !reset;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!tx_rdy) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (tx_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign tx_load = pop;
   assign irq_set = int_en_q && pop && !data_wr
                    && (fifo_count == LW_HI);

   // config shadow, status flags, interrupt and data latch
   always_comb begin
      shadow_d = shadow_q;
      int_en_d = int_en_q;
      pend_d   = pend_q;
      line_d   = line_q;
      ovf_d    = ovf_q;
      irq_d    = irq_q;
      txd_d    = txd_q;
      if (cfg_wr) begin
         shadow_d = cfg_decode(out_port[7:0]);
         int_en_d = out_port[CFG_INTEN];
         pend_d   = 1'b1;
      end else if (apply) begin
         pend_d   = 1'b0;
      end
      if (apply) line_d = shadow_q;
      if (stat_wr) begin
         ovf_d = 1'b0;
      end else if (data_wr && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end
      if (irq_set) begin
         irq_d = 1'b1;
      end else if (interrupt_ack) begin
         irq_d = 1'b0;
      end
      if (state_q == ST_IDLE && state_d == ST_LOAD) begin
         txd_d = fifo_head;
      end
   end

   // all control state, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         shadow_q <= LINE_CFG_RST;
         line_q   <= LINE_CFG_RST;
         int_en_q <= 1'b0;
         pend_q   <= 1'b0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
         txd_q    <= 8'h00;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         line_q   <= line_d;
         int_en_q <= int_en_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
         txd_q    <= txd_d;
      end
   end

   // status word with count saturated to four bits
   always_comb begin
      cnt_ext  = 32'(fifo_count);
      cnt_disp = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
      in_port  = 16'h0000;
      if (port_id == STAT_PORT) begin
         in_port = {8'h00, irq_q, ovf_q, fifo_empty,
                    fifo_full, cnt_disp};
      end
   end

   assign interrupt = irq_q;
   assign tx_data   = txd_q;
   assign baud_sel  = line_q.baud;
   assign eight     = line_q.eight;
   assign pen       = line_q.pen;
   assign ohel      = line_q.ohel;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Hardware sequencer between the tramelblaze port bus and the UART TX engine. It buffers bytes written by the processor in a small FIFO and launches them into the TX engine one frame at a time, using the engine's tx_rdy handshake. It holds shadowed line configuration (baud select, Eight, Pen, OHEL) and applies it only between frames. It raises a low-water interrupt to the processor, so firmware refills in bursts instead of servicing every byte.

Parameters:
DEPTH, 8, FIFO depth in bytes (power of 2, >=4)
LOW_WATER, 2, interrupt fires when a pop makes count fall from LOW_WATER+1 to LOW_WATER
DATA_PORT, 16'h0000, port_id for FIFO push
CFG_PORT, 16'h0001, port_id for config write
STAT_PORT, 16'h0002, port_id for status read / overflow clear

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
port_id  in  16  processor port address
write_strobe  in  1  processor write qualifier
out_port  in  16  processor write data; [7:0] used
in_port  out  16  status read data (combinational)
interrupt_ack  in  1  processor interrupt acknowledge
interrupt  out  1  level interrupt request
tx_rdy  in  1  TX engine idle/ready
tx_load  out  1  one-cycle launch strobe to TX engine
tx_data  out  8  byte presented with tx_load
baud_sel  out  4  applied baud select
eight  out  1  applied 8-bit mode
pen  out  1  applied parity enable
ohel  out  1  applied odd/even parity select

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All state clears on the reset edge.
- Reset values: tx_load=0, tx_data=0, interrupt=0, baud_sel=0, eight=1, pen=0, ohel=0. FIFO is empty, overflow=0, int_en=0, no config is pending, and the FSM is in IDLE.
- Push: write_strobe && port_id==DATA_PORT pushes out_port[7:0].
  - Push when full with no same-cycle pop: data is dropped and sticky overflow is set.
  - Push when full with a same-cycle pop: push is accepted.
  - Push and pop in the same cycle when not full: count is unchanged.
- Config write: write_strobe && port_id==CFG_PORT captures the shadow config and sets cfg_pending.
  - Field map: [3:0] baud_sel, [4] eight, [5] pen, [6] ohel, [7] int_en.
  - int_en takes effect immediately. The line fields wait for application.
  - A second write before application overwrites the shadow.
- write_strobe && port_id==STAT_PORT clears overflow.
- in_port = {8'h00, interrupt, overflow, empty, full, count[3:0]} when port_id==STAT_PORT, else 16'h0000. count saturates display at 4 bits.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
  - IDLE: if tx_rdy && cfg_pending, copy shadow to line outputs, clear cfg_pending, stay in IDLE. Config takes priority over launch.
  - IDLE: else if tx_rdy && !empty, go to LOAD.
  - LOAD (one cycle): tx_load=1, tx_data=FIFO head, pop. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_rdy==0, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_rdy==1, then go to IDLE.
- Latency: a push sampled at edge k into an empty FIFO, with the FSM in IDLE, tx_rdy=1 and no pending config, gives tx_load high in the cycle after edge k+1. Back-to-back frames are separated by at least one IDLE cycle.
- Line outputs never change while the FSM is outside IDLE.
- Interrupt:
  - Set when int_en=1 and a pop takes count from LOW_WATER+1 to LOW_WATER with no same-cycle push.
  - Cleared by interrupt_ack.
  - If set and ack occur in the same cycle, set wins.
  - Clearing int_en does not clear a pending interrupt.
- Reset mid-frame: the FSM returns to IDLE and queued bytes are discarded. No tx_load is issued in the reset cycle.

Decomposition:
- Shared package: port address constants, config field bit positions, FSM state encoding, reset config value.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count, synchronous reset, accept-on-full-with-pop rule).

Test Plan:
- Reset, then write 8'h41 to DATA_PORT with tx_rdy=1 -> tx_load pulses 1 cycle with tx_data=8'h41, 2 edges after the write. The FSM waits for tx_rdy to fall then rise, and status count returns to 0.
- Write 10 bytes with tx_rdy held 0 -> first 8 are queued, full=1, overflow=1. A write to STAT_PORT clears overflow, and bytes 9-10 are never transmitted.
- With int_en=1, queue 4 bytes and drain via a TX model (tx_rdy low 20 cycles per frame) -> interrupt rises on the pop leaving count=2. interrupt_ack drops it, and no re-fire occurs as count falls to 0.
- Write CFG_PORT=8'h3B mid-frame -> baud_sel/eight/pen/ohel unchanged until tx_rdy returns. They are applied in IDLE (baud_sel=4'hB, eight=1, pen=1, ohel=0) before the next tx_load.
- Assert reset while in WAIT_DONE with 3 bytes queued -> the next cycle shows empty, tx_load=0 and interrupt=0. No further loads occur after tx_rdy returns.
- Pulse interrupt_ack in the same cycle as a low-water crossing -> interrupt=1 after the edge.
